udma_eth_rx_packer: RTL

- Sits directly downstream of the RGMII MAC core's receive AXI-Stream byte output. The MAC drives rx_axis_tready tied high, so this block never backpressures.
- Packs received bytes little-endian into 32-bit words and buffers them in a small FIFO.
- Appends one status word per frame and presents words to the uDMA RX channel over a valid/ready interface.
- Absorbs uDMA stalls by truncating frames cleanly; it never corrupts word alignment.

---
 rtl/udma_eth_rx_packer_pkg.sv | 42 ++++
 rtl/udma_eth_rx_packer_if.sv | 26 ++
 rtl/udma_eth_sync_fifo.sv | 63 ++++++
 rtl/udma_eth_rx_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/udma_eth_rx_packer_pkg.sv
// Shared types and constants for the uDMA Ethernet RX packer:
// framing FSM states, status-word field positions and FIFO entry layout.
package udma_eth_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FRAME  = 2'd1,
      DROP   = 2'd2,
      STATUS = 2'd3
   } state_e;

   localparam int DATA_W      = 32;
   localparam int ENTRY_W     = 33;   // {status flag, 32-bit word}
   localparam int FLAG_BIT    = 32;

   localparam int LEN_LSB     = 0;
   localparam int LEN_W       = 16;
   localparam int BAD_BIT     = 16;
   localparam int TRUNC_BIT   = 17;
   localparam int SEQ_LSB     = 24;
   localparam int SEQ_W       = 8;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Assemble the per-frame status word.
   function automatic logic [DATA_W-1:0] make_status(input logic [LEN_W-1:0] len,
                                                     input logic             bad,
                                                     input logic             trunc,
                                                     input logic [SEQ_W-1:0] seq);
      logic [DATA_W-1:0] w;
      w                          = '0;
      w[LEN_LSB +: LEN_W]        = len;
      w[BAD_BIT]                 = bad;
      w[TRUNC_BIT]               = trunc;
      w[SEQ_LSB +: SEQ_W]        = seq;
      return w;
   endfunction

endpackage

// File: rtl/udma_eth_rx_packer_if.sv
// Receive-side bus bundle: MAC byte stream in, packed word stream out to the uDMA.
// slave  = the packer's view, master = the surrounding MAC/uDMA view.
interface udma_eth_rx_packer_if;
   import udma_eth_pkg::*;

   logic [7:0]        rx_axis_tdata;
   logic              rx_axis_tvalid;
   logic              rx_axis_tlast;
   logic              rx_axis_tuser;

   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic              ready_i;
   logic              status_o;

   modport slave (
      input  rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser, ready_i,
      output data_o, valid_o, status_o
   );

   modport master (
      output rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser, ready_i,
      input  data_o, valid_o, status_o
   );

endinterface

// File: rtl/udma_eth_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with a free-entry count.
// DEPTH must be a power of two so the pointers wrap naturally.
module udma_eth_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_pop_data,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_free
);

   localparam int              AW      = $clog2(DEPTH);
   localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0]   PTR_ONE = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign o_empty    = (r_count == '0);
   assign w_full     = (r_count == DEPTH_C);
   assign w_do_pop   = i_pop && !o_empty;
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign w_do_push  = i_push && (!w_full || w_do_pop);
   assign o_pop_data = r_mem[r_rd_ptr];
   assign o_free     = DEPTH_C - r_count;

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage.
   // NOTE: storage is deliberately not reset; the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/udma_eth_rx_packer.sv
// uDMA Ethernet RX packer: packs MAC receive bytes little-endian into 32-bit
// words, terminates every frame with a status word, and truncates frames
// cleanly when the output FIFO cannot hold another data word plus the status.
// Optional frame statistics counters: define UDMA_ETH_RX_STATS_EN.
module udma_eth_rx_packer
   import udma_eth_pkg::*;
#(
   parameter int FIFO_DEPTH    = 16,
   parameter int MAX_FRAME_LEN = 1518
) (
   input  logic                  clk,
   input  logic                  rst,
   udma_eth_rx_packer_if.slave   bus,
   output logic                  drop_o,
   output logic [15:0]           stat_good_o,
   output logic [15:0]           stat_bad_o,
   output logic [15:0]           stat_drop_o
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] MIN_FREE = (AW+1)'(2);

   state_e             r_state;
   state_e             w_next_state;
   logic [LEN_W-1:0]   r_len;
   logic               r_bad;
   logic               r_trunc;
   logic [SEQ_W-1:0]   r_seq;
   logic [23:0]        r_pack;       // bytes 0..2 of the word being built
   logic [1:0]         r_bcnt;       // lane of the next byte
   logic               r_flush;      // one-byte frame deferred behind a status write
   logic               r_drop;

   logic               w_vld;
   logic               w_last;
   logic               w_user;
   logic [7:0]         w_byte;
   logic               w_start;
   logic               w_frame_byte;
   logic               w_oversize;
   logic               w_pack_byte;
   logic               w_word_end;
   logic               w_defer;
   logic               w_data_req;
   logic               w_space;
   logic               w_trunc_evt;
   logic               w_status_push;
   logic [DATA_W-1:0]  w_word;
   logic               w_push;
   logic [ENTRY_W-1:0] w_push_entry;
   logic [ENTRY_W-1:0] w_head;
   logic               w_empty;
   logic [AW:0]        w_free;

   assign w_vld  = bus.rx_axis_tvalid;
   assign w_last = bus.rx_axis_tlast;
   assign w_user = bus.rx_axis_tuser;
   assign w_byte = bus.rx_axis_tdata;

   // Byte 0 of a new frame: from IDLE, or overlapping the previous frame's status write.
   assign w_start       = w_vld && ((r_state == IDLE) || ((r_state == STATUS) && !r_flush));
   assign w_frame_byte  = w_vld && (r_state == FRAME);
   assign w_oversize    = w_frame_byte && ({1'b0, r_len} >= 17'(MAX_FRAME_LEN));
   assign w_pack_byte   = w_start || (w_frame_byte && !w_oversize);
   assign w_word_end    = w_pack_byte && ((r_bcnt == 2'd3) || w_last);
   // A one-byte frame arriving during STATUS cannot share the single write port.
   assign w_defer       = w_start && (r_state == STATUS) && w_last;
   assign w_data_req    = (w_word_end && !w_defer) || ((r_state == STATUS) && r_flush);
   assign w_space       = (w_free >= MIN_FREE);
   assign w_trunc_evt   = w_oversize || (w_data_req && !w_space);
   assign w_status_push = (r_state == STATUS) && !r_flush;

   // Current byte merged into its lane of the word being built; upper lanes are zero.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_word = {8'h00, r_pack};
      case (r_bcnt)
         2'd0:    w_word[7:0]   = w_byte;
         2'd1:    w_word[15:8]  = w_byte;
         2'd2:    w_word[23:16] = w_byte;
         default: w_word[31:24] = w_byte;
      endcase
   end

   // Framing state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // Framing next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_vld) w_next_state = w_last ? STATUS : FRAME;
         end
         FRAME: begin
            if (w_vld) begin
               if (w_last)           w_next_state = STATUS;
               else if (w_trunc_evt) w_next_state = DROP;
            end
         end
         DROP: begin
            if (w_vld && w_last) w_next_state = STATUS;
         end
         default: begin
            if (r_flush)    w_next_state = STATUS;
            else if (w_vld) w_next_state = w_last ? STATUS : FRAME;
            else            w_next_state = IDLE;
         end
      endcase
   end

   // Framing outputs: which entry, if any, goes into the FIFO this cycle.
   always_comb begin
      w_push       = 1'b0;
      w_push_entry = '0;
      case (r_state)
         IDLE, FRAME: begin
            if (w_data_req && w_space) begin
               w_push       = 1'b1;
               w_push_entry = {1'b0, w_word};
            end
         end
         STATUS: begin
            if (r_flush) begin
               if (w_space) begin
                  w_push       = 1'b1;
                  w_push_entry = {1'b0, 8'h00, r_pack};
               end
            end else begin
               w_push       = 1'b1;
               w_push_entry = {1'b1, make_status(r_len, r_bad, r_trunc, r_seq)};
            end
         end
         default: begin
            w_push       = 1'b0;
            w_push_entry = '0;
         end
      endcase
   end

   // Per-frame bookkeeping: length, flags, sequence number and the partial word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len   <= '0;
         r_bad   <= 1'b0;
         r_trunc <= 1'b0;
         r_seq   <= '0;
         r_pack  <= '0;
         r_bcnt  <= '0;
         r_flush <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         if (w_start) begin
            r_len   <= 16'd1;
            r_bad   <= w_user && w_last;
            r_trunc <= 1'b0;
         end else if (w_vld && ((r_state == FRAME) || (r_state == DROP))) begin
            r_len <= sat_inc16(r_len);
            if (w_last) r_bad <= w_user;
         end
         if (w_trunc_evt) r_trunc <= 1'b1;

         r_drop  <= w_trunc_evt;
         r_flush <= w_defer;
         if (w_status_push) r_seq <= r_seq + 8'd1;

         if (w_trunc_evt || ((r_state == STATUS) && r_flush)) begin
            r_pack <= '0;
            r_bcnt <= '0;
         end else if (w_pack_byte) begin
            if (w_word_end && !w_defer) begin
               r_pack <= '0;
               r_bcnt <= '0;
            end else begin
               r_pack <= w_word[23:0];
               r_bcnt <= r_bcnt + 2'd1;
            end
         end
      end
   end

   udma_eth_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (bus.ready_i),
      .o_pop_data  (w_head),
      .o_empty     (w_empty),
      .o_free      (w_free)
   );

   assign bus.valid_o  = !w_empty;
   assign bus.data_o   = w_empty ? '0 : w_head[DATA_W-1:0];
   assign bus.status_o = !w_empty && w_head[FLAG_BIT];
   assign drop_o       = r_drop;

`ifdef UDMA_ETH_RX_STATS_EN
   logic [15:0] r_stat_good;
   logic [15:0] r_stat_bad;
   logic [15:0] r_stat_drop;

   // Frame classification counters, updated as each status word is written.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_good <= '0;
         r_stat_bad  <= '0;
         r_stat_drop <= '0;
      end else if (w_status_push) begin
         if (!r_bad && !r_trunc) r_stat_good <= sat_inc16(r_stat_good);
         if (r_bad)              r_stat_bad  <= sat_inc16(r_stat_bad);
         if (r_trunc)            r_stat_drop <= sat_inc16(r_stat_drop);
      end
   end

   assign stat_good_o = r_stat_good;
   assign stat_bad_o  = r_stat_bad;
   assign stat_drop_o = r_stat_drop;
`else
   assign stat_good_o = '0;
   assign stat_bad_o  = '0;
   assign stat_drop_o = '0;
`endif

endmodule
